// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and the data-bit count.
// Kept separate so the receiver can reuse the same encoding.
package uart_pkg;
  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered not-full flag.
// The head word is always visible on rdata_o while the FIFO is non-empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             ready_o
);
  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_check
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign ready_o = ready_q;

  // Ready is computed from the post-edge pointers, so a pop in a full cycle
  // only re-opens the FIFO on the following cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    ready_d  = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: bytes queue in a small FIFO and are
// serialised LSB first with back-to-back frames when more data is waiting.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TXD,
  output logic       busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_baud_check
    $error("uart_tx: CLK_FREQ_HZ / BAUD must be at least 2");
  end

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 baud_done;
  logic                 fifo_pop, fifo_empty;
  logic [7:0]           fifo_rdata;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .ready_o (tx_ready)
  );

  assign baud_done = (baud_q == '0);
  assign TXD       = txd_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

  // TXD is updated together with the state, so every bit's line level is
  // already registered on the edge that starts that bit.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = BIT_LOAD;
          txd_d    = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d    = BIT_LOAD;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
          state_d   = DATA;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = BIT_LOAD;
          if (bit_idx_q == LAST_BIT) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            baud_d   = BIT_LOAD;
            txd_d    = 1'b0;
            state_d  = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
    end
  end

  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
  end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes are queued, and a line monitor
// decodes every frame on TXD and checks it bit-slot by bit-slot.
module tb_uart_tx;
  localparam int CLK_FREQ_HZ = 460800;
  localparam int BAUD        = 115200;
  localparam int FIFO_DEPTH  = 4;
  localparam int CPB         = CLK_FREQ_HZ / BAUD;
  localparam int FRAME       = 10 * CPB;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, TXD, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] sb[$];
  bit mon_flush = 1'b0;
  int frames_started = 0;
  int frames_done = 0;
  int last_start_cyc = -100;
  int gaps[256];

  uart_tx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .TXD      (TXD),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Line level of 8N1 slot s (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return 1'(({24'd0, b} >> (s - 1)) & 32'd1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    bit         in_frame = 1'b0;
    bit         skip = 1'b0;
    bit         bad = 1'b0;
    int         idx = 0;
    int         idle_cnt = 0;
    int         bad_idx = 0;
    logic       bad_val = 1'b0;
    logic [7:0] cur = 8'h00;
    forever begin
      @(negedge CLK);
      if (mon_flush) begin
        sb.delete();
        in_frame = 1'b0;
        idle_cnt = 0;
      end else if (!in_frame) begin
        if (TXD !== 1'b1) begin
          gaps[frames_started % 256] = idle_cnt;
          frames_started++;
          last_start_cyc = cyc;
          idle_cnt = 0;
          in_frame = 1'b1;
          idx = 1;
          bad = 1'b0;
          skip = 1'b0;
          if (sb.size() == 0) begin
            tests++;
            fails++;
            skip = 1'b1;
            $display("FAIL unexpected_frame: start bit at cycle %0d, expected no frame", cyc);
          end else begin
            cur = sb.pop_front();
          end
        end else begin
          idle_cnt++;
        end
      end else begin
        if (!bad && (TXD !== frame_bit(cur, idx / CPB))) begin
          bad = 1'b1;
          bad_idx = idx;
          bad_val = TXD;
        end
        idx++;
        if (idx == FRAME) begin
          in_frame = 1'b0;
          frames_done++;
          if (!skip) begin
            tests++;
            if (bad) begin
              fails++;
              $display("FAIL frame_%02h: TXD at cycle %0d of frame was %b, expected %b",
                       cur, bad_idx, bad_val, frame_bit(cur, bad_idx / CPB));
            end
          end
        end
      end
    end
  endtask

  task automatic push_wait(input logic [7:0] b, output int acc_cyc);
    int n = 0;
    acc_cyc = -1;
    tx_data = b;
    tx_valid = 1'b1;
    while (acc_cyc < 0 && n < 2000) begin
      if (tx_ready === 1'b1 && !RESET) begin
        sb.push_back(b);
        acc_cyc = cyc + 1;
      end
      @(negedge CLK);
      n++;
    end
    tx_valid = 1'b0;
    if (acc_cyc < 0) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: byte %02h not accepted in 2000 cycles, expected acceptance", b);
    end
  endtask

  task automatic try_push(input logic [7:0] b, output bit acc);
    tx_data = b;
    tx_valid = 1'b1;
    acc = (tx_ready === 1'b1);
    if (acc) sb.push_back(b);
    @(negedge CLK);
    tx_valid = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  task automatic run();
    int a, a2, base, nacc, nz, lows, fs;
    bit acc;
    logic [7:0] burst[5] = '{8'h00, 8'hFF, 8'h55, 8'h81, 8'h3C};

    // Reset with tx_valid held high: nothing may be queued.
    tx_valid = 1'b1;
    tx_data = 8'h99;
    repeat (4) @(negedge CLK);
    check("reset_txd", int'(TXD), 1);
    check("reset_ready", int'(tx_ready), 1);
    check("reset_busy", int'(busy), 0);
    RESET = 1'b0;
    tx_valid = 1'b0;
    repeat (5) @(negedge CLK);
    check("post_reset_busy", int'(busy), 0);

    // Single byte 0xA5: timing of start, busy drop and idle line.
    push_wait(8'hA5, a);
    wait_until(a + FRAME);
    check("a5_busy_in_stop", int'(busy), 1);
    @(negedge CLK);
    check("a5_busy_after_stop", int'(busy), 0);
    check("a5_txd_idle", int'(TXD), 1);
    check("a5_latency", last_start_cyc, a + 1);
    lows = 0;
    repeat (10) begin
      @(negedge CLK);
      if (TXD !== 1'b1) lows++;
    end
    check("a5_line_stays_high", lows, 0);

    // Latency with 0x01 from idle.
    push_wait(8'h01, a);
    repeat (3) @(negedge CLK);
    check("latency_01", last_start_cyc, a + 1);
    wait_idle("idle_after_01", 200);

    // Burst behind a frame already in progress.
    base = frames_started;
    push_wait(8'hC3, a);
    repeat (2) @(negedge CLK);
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      try_push(burst[i], acc);
      if (acc) nacc++;
      if (i == 4) check("burst_3c_rejected", int'(acc), 0);
    end
    check("burst_accepts", nacc, 4);
    check("burst_ready_low", int'(tx_ready), 0);
    push_wait(8'h3C, a2);
    wait_idle("idle_after_burst", 1000);
    check("burst_frames", frames_started - base, 6);
    nz = 0;
    for (int k = 1; k <= 5; k++) if (gaps[(base + k) % 256] != 0) nz++;
    check("burst_gapless", nz, 0);

    // Full FIFO with tx_valid held across the first pop.
    push_wait(8'h5A, a);
    repeat (2) @(negedge CLK);
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      try_push(8'(8'h10 + i), acc);
      if (acc) nacc++;
    end
    check("fill_accepts", nacc, 4);
    check("fill_ready_low", int'(tx_ready), 0);
    push_wait(8'hE7, a2);
    repeat (3) @(negedge CLK);
    check("accept_after_pop", a2, last_start_cyc + 1);
    wait_idle("idle_after_fill", 1000);

    // Reset during data bit 3 of 0x0F with two bytes queued.
    push_wait(8'h0F, a);
    try_push(8'h11, acc);
    try_push(8'h22, acc);
    wait_until(a + 1 + 17);
    mon_flush = 1'b1;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("midreset_txd", int'(TXD), 1);
    check("midreset_ready", int'(tx_ready), 1);
    check("midreset_busy", int'(busy), 0);
    @(negedge CLK);
    mon_flush = 1'b0;
    fs = frames_started;
    lows = 0;
    repeat (120) begin
      @(negedge CLK);
      if (TXD !== 1'b1) lows++;
    end
    check("midreset_no_frames", frames_started - fs, 0);
    check("midreset_line_high", lows, 0);

    // Randomised traffic.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) try_push(8'($urandom), acc);
      else @(negedge CLK);
    end
    wait_idle("idle_after_random", 20000);
    check("random_all_sent", sb.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      run();
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
